// File: rtl/label_equiv_resolver_pkg.sv
// Shared definitions for the label equivalence resolver: FSM state encoding,
// the default label width and the FIFO pointer-width helper.
package label_equiv_resolver_pkg;

  localparam int DEFAULT_LABEL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIND_A  = 3'd1,
    ST_FIND_B  = 3'd2,
    ST_UNITE   = 3'd3,
    ST_FLATTEN = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/label_equiv_resolver_merge_fifo.sv
// Synchronous show-ahead FIFO holding pending merge pairs. The head entry is
// visible on pop_data whenever empty is low, so the consumer can load it in
// the same cycle it pops. flush empties the FIFO synchronously.
module merge_fifo
  import label_equiv_resolver_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 2 * DEFAULT_LABEL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int               PTR_W   = fifo_ptr_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              push_en, pop_en;

  assign full     = (count_reg == DEPTH_C);
  assign empty    = (count_reg == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage write port; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/label_equiv_resolver.sv
// Union-find label equivalence engine. Allocates provisional labels, queues
// merge pairs, resolves each pair by walking both chains to their roots and
// linking the larger root under the smaller one, then flattens the table in a
// single ascending pass at frame end. Because every link points downward
// (parent[i] <= i), parent[parent[i]] is already final when i is visited.
module label_equiv_resolver
  import label_equiv_resolver_pkg::*;
#(
  parameter int LABEL_W    = DEFAULT_LABEL_W,
  parameter int MAX_LABEL  = 2**LABEL_W - 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               alloc,
  output logic [LABEL_W-1:0] alloc_label,
  input  logic               merge_valid,
  output logic               merge_ready,
  input  logic [LABEL_W-1:0] merge_a,
  input  logic [LABEL_W-1:0] merge_b,
  input  logic [LABEL_W-1:0] lookup_addr,
  output logic [LABEL_W-1:0] lookup_label,
  output logic               busy,
  output logic               resolved,
  output logic               overflow
);

  localparam logic [LABEL_W-1:0] MAX_L = LABEL_W'(MAX_LABEL);
  localparam logic [LABEL_W-1:0] ONE   = LABEL_W'(1);

  state_e               state_reg, state_next;
  logic [LABEL_W-1:0]   xa_reg, xa_next, xb_reg, xb_next, idx_reg, idx_next;
  logic [LABEL_W-1:0]   counter_reg, lookup_reg;
  logic                 overflow_reg, pend_reg;
  logic                 wr_en;
  logic [LABEL_W-1:0]   wr_addr, wr_data;
  logic [LABEL_W-1:0]   hop_a, hop_b, flat_data;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*LABEL_W-1:0] fifo_rd;

  // Read view of the table: entry 0 is a constant background slot.
  logic [LABEL_W-1:0]   parent_arr [0:MAX_LABEL];
  logic [MAX_LABEL:0]   valid_vec;

  assign parent_arr[0] = '0;
  assign valid_vec[0]  = 1'b0;

  // Each table entry owns its parent value and valid bit.
  for (genvar gi = 1; gi <= MAX_LABEL; gi++) begin : g_entry
    logic [LABEL_W-1:0] parent_q;
    logic               valid_q;
    logic               hit;

    assign hit            = wr_en && (wr_addr == LABEL_W'(gi));
    assign parent_arr[gi] = parent_q;
    assign valid_vec[gi]  = valid_q;

    // Valid bit: cleared for a new frame, set by any table write.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         valid_q <= 1'b0;
      else if (frame_start) valid_q <= 1'b0;
      else if (hit)         valid_q <= 1'b1;
    end

    // Parent value is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
      if (hit) parent_q <= wr_data;
    end
  end

  // One step up the tree; an entry never written is its own root.
  function automatic logic [LABEL_W-1:0] hop(input logic [LABEL_W-1:0] a);
    if (a == '0 || int'(a) > MAX_LABEL) return a;
    return valid_vec[a] ? parent_arr[a] : a;
  endfunction

  // Table read ports used by the FSM.
  always_comb begin
    hop_a     = hop(xa_reg);
    hop_b     = hop(xb_reg);
    flat_data = hop(hop(idx_reg));
  end

  assign fifo_push = merge_valid && merge_ready &&
                     (merge_a != merge_b) && (merge_a != '0) && (merge_b != '0);

  merge_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (2 * LABEL_W)
  ) u_merge_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data ({merge_a, merge_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign alloc_label  = counter_reg;
  assign lookup_label = lookup_reg;
  assign overflow     = overflow_reg;
  assign resolved     = (state_reg == ST_DONE);
  assign merge_ready  = !fifo_full && !pend_reg && !resolved;
  assign busy         = ((state_reg != ST_IDLE) && (state_reg != ST_DONE)) || !fifo_empty;

  // Label allocator: saturates at MAX_LABEL and flags the overflow stickily.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_reg  <= ONE;
      overflow_reg <= 1'b0;
    end else if (frame_start) begin
      counter_reg  <= ONE;
    end else if (alloc) begin
      if (counter_reg < MAX_L) counter_reg  <= counter_reg + ONE;
      else                     overflow_reg <= 1'b1;
    end
  end

  // Registered lookup port and the latched flatten request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lookup_reg <= '0;
      pend_reg   <= 1'b0;
    end else begin
      lookup_reg <= hop(lookup_addr);
      if (frame_start)                           pend_reg <= 1'b0;
      else if (frame_end && state_reg != ST_DONE) pend_reg <= 1'b1;
    end
  end

  // FSM state and working registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      xa_reg    <= '0;
      xb_reg    <= '0;
      idx_reg   <= ONE;
    end else begin
      state_reg <= state_next;
      xa_reg    <= xa_next;
      xb_reg    <= xb_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic: pop, find both roots, unite, or flatten the table.
  always_comb begin
    state_next = state_reg;
    xa_next    = xa_reg;
    xb_next    = xb_reg;
    idx_next   = idx_reg;
    fifo_pop   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = idx_reg;
    wr_data    = '0;
    if (frame_start) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            xa_next    = fifo_rd[2*LABEL_W-1:LABEL_W];
            xb_next    = fifo_rd[LABEL_W-1:0];
            state_next = ST_FIND_A;
          end else if (pend_reg) begin
            idx_next   = ONE;
            // With nothing allocated there is nothing to flatten.
            state_next = (counter_reg > ONE) ? ST_FLATTEN : ST_DONE;
          end
        end
        ST_FIND_A: begin
          if (hop_a == xa_reg) state_next = ST_FIND_B;
          else                 xa_next    = hop_a;
        end
        ST_FIND_B: begin
          if (hop_b == xb_reg) state_next = ST_UNITE;
          else                 xb_next    = hop_b;
        end
        ST_UNITE: begin
          if (xa_reg != xb_reg) begin
            wr_en   = 1'b1;
            wr_addr = (xa_reg > xb_reg) ? xa_reg : xb_reg;
            wr_data = (xa_reg > xb_reg) ? xb_reg : xa_reg;
          end
          state_next = ST_IDLE;
        end
        ST_FLATTEN: begin
          wr_en    = 1'b1;
          wr_addr  = idx_reg;
          wr_data  = flat_data;
          idx_next = idx_reg + ONE;
          if (idx_reg == counter_reg - ONE) state_next = ST_DONE;
        end
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_label_equiv_resolver.sv
// Directed bench for label_equiv_resolver: allocation, merging, flattening,
// degenerate merges, FIFO back-pressure, saturation, abort and async reset.
module tb_label_equiv_resolver;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_n, frame_start, frame_end, alloc, merge_valid;
  logic [LW-1:0] merge_a, merge_b, lookup_addr;
  logic [LW-1:0] alloc_label, lookup_label;
  logic          merge_ready, busy, resolved, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  label_equiv_resolver #(
    .LABEL_W    (LW),
    .MAX_LABEL  (255),
    .FIFO_DEPTH (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .alloc        (alloc),
    .alloc_label  (alloc_label),
    .merge_valid  (merge_valid),
    .merge_ready  (merge_ready),
    .merge_a      (merge_a),
    .merge_b      (merge_b),
    .lookup_addr  (lookup_addr),
    .lookup_label (lookup_label),
    .busy         (busy),
    .resolved     (resolved),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic do_alloc(input int n);
    alloc = 1'b1;
    repeat (n) step();
    alloc = 1'b0;
  endtask

  task automatic push_merge(input int a, input int b);
    int n = 0;
    while (!merge_ready && n < 300) begin
      step();
      n++;
    end
    if (!merge_ready) check($sformatf("merge_ready for (%0d,%0d)", a, b), merge_ready, 1);
    merge_a     = LW'(a);
    merge_b     = LW'(b);
    merge_valid = 1'b1;
    step();
    merge_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_resolved(input string tag);
    int n = 0;
    while (!resolved && n < 1000) begin
      step();
      n++;
    end
    check(tag, resolved, 1);
  endtask

  task automatic expect_lookup(input string tag, input int addr, input int exp);
    lookup_addr = LW'(addr);
    step();
    check($sformatf("%s lookup %0d", tag, addr), lookup_label, exp);
  endtask

  initial begin
    int  p, guard;
    bit  acc, saw_full;

    reset_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; alloc = 1'b0;
    merge_valid = 1'b0; merge_a = '0; merge_b = '0; lookup_addr = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst alloc_label",  alloc_label,  1);
    check("rst merge_ready",  merge_ready,  1);
    check("rst lookup_label", lookup_label, 0);
    check("rst busy",         busy,         0);
    check("rst resolved",     resolved,     0);
    check("rst overflow",     overflow,     0);
    reset_n = 1'b1;
    step();

    // Basic chain merge and flatten.
    do_alloc(5);
    check("t1 alloc_label after 5", alloc_label, 6);
    push_merge(2, 1);
    push_merge(3, 2);
    push_merge(5, 4);
    push_merge(4, 3);
    pulse_frame_end();
    check("t1 merge_ready after frame_end", merge_ready, 0);
    wait_resolved("t1 resolved");
    for (int k = 1; k <= 5; k++) expect_lookup("t1", k, 1);
    expect_lookup("t1", 0, 0);
    check("t1 merge_ready while resolved", merge_ready, 0);

    // Degenerate merges never touch the table.
    pulse_frame_start();
    check("t2 alloc_label after frame_start", alloc_label, 1);
    check("t2 resolved cleared", resolved, 0);
    check("t2 merge_ready reopened", merge_ready, 1);
    do_alloc(3);
    push_merge(3, 3);
    push_merge(0, 2);
    check("t2 busy after degenerate", busy, 0);
    pulse_frame_end();
    wait_resolved("t2 resolved");
    expect_lookup("t2", 1, 1);
    expect_lookup("t2", 2, 2);
    expect_lookup("t2", 3, 3);

    // Back-to-back pairs overrun the resolver and fill the FIFO.
    pulse_frame_start();
    do_alloc(30);
    check("t3 alloc_label after 30", alloc_label, 31);
    p = 1; guard = 0; saw_full = 1'b0;
    while (p <= 29 && guard < 600) begin
      merge_a     = LW'(p + 1);
      merge_b     = LW'(p);
      merge_valid = 1'b1;
      acc = merge_ready;
      if (!merge_ready) saw_full = 1'b1;
      step();
      guard++;
      if (acc) p++;
    end
    merge_valid = 1'b0;
    check("t3 pairs accepted", p - 1, 29);
    check("t3 merge_ready dropped", saw_full, 1);
    pulse_frame_end();
    wait_resolved("t3 resolved");
    for (int k = 1; k <= 30; k++) expect_lookup("t3", k, 1);

    // Allocation saturation and sticky overflow.
    pulse_frame_start();
    do_alloc(254);
    check("t4 alloc_label at 254 allocs", alloc_label, 255);
    check("t4 overflow before saturation", overflow, 0);
    do_alloc(2);
    check("t4 alloc_label saturated", alloc_label, 255);
    check("t4 overflow set", overflow, 1);
    pulse_frame_start();
    check("t4 overflow kept over frame_start", overflow, 1);
    check("t4 alloc_label restarted", alloc_label, 1);

    // Abort while walking the second chain.
    do_alloc(8);
    push_merge(3, 2);
    push_merge(2, 1);
    wait_idle("t5 idle before abort");
    push_merge(7, 3);
    step();
    step();
    check("t5 busy in FIND_B", busy, 1);
    pulse_frame_start();
    check("t5 busy after abort", busy, 0);
    check("t5 alloc_label after abort", alloc_label, 1);
    expect_lookup("t5", 7, 7);
    expect_lookup("t5", 3, 3);

    // Asynchronous reset in the middle of flattening.
    pulse_frame_start();
    do_alloc(10);
    push_merge(2, 1);
    push_merge(10, 9);
    wait_idle("t6 idle before flatten");
    lookup_addr = 8'd10;
    pulse_frame_end();
    step(); step(); step();
    check("t6 busy mid-flatten", busy, 1);
    check("t6 lookup before reset", lookup_label, 9);
    #3 reset_n = 1'b0;
    #1;
    check("t6 async alloc_label",  alloc_label,  1);
    check("t6 async merge_ready",  merge_ready,  1);
    check("t6 async lookup_label", lookup_label, 0);
    check("t6 async busy",         busy,         0);
    check("t6 async resolved",     resolved,     0);
    check("t6 async overflow",     overflow,     0);
    #2 reset_n = 1'b1;
    step();
    do_alloc(4);
    push_merge(4, 2);
    push_merge(3, 1);
    push_merge(2, 1);
    pulse_frame_end();
    wait_resolved("t6 resolved after reset");
    for (int k = 1; k <= 4; k++) expect_lookup("t6", k, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
